// File: rtl/adc_multislope_seq.sv
// adc_multislope_seq
// Sequencer for the multi-slope integrating ADC front end. On an accepted
// start it shorts the integrator, runs nosc run-up periods (reference polarity
// chosen from the comparator at each period start, fixed P reference for the
// last FIX_CLKS clocks of each period), then runs a single-slope rundown to
// the comparator zero crossing and reports the raw counts.
//
// Optional feature macro: ADC_RUNDOWN_TIMEOUT_EN
//   defined     : rundown aborts with err=1 once count_rundown hits RUNDOWN_MAX
//   not defined : rundown waits indefinitely, err stays 0
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          conversion request (sampled in IDLE only)
//   nosc[15:0]     run-up periods per conversion (latched on accepted start)
//   cmpr_in        comparator output, asynchronous to clk
//   mux[2:0]       {sig, n_ref, p_ref} switch controls, 1 = on
//   int_rst        integrator short switch, 1 = shorted
//   cmpr_latch     comparator latch, 0 = transparent, 1 = held
//   busy           high from accepted start until done
//   done           one-cycle pulse, results valid
//   count_p/_n     periods whose variable phase used P / N reference
//   count_rundown  rundown duration in clocks (saturating)
//   rundown_dir    1 = rundown used N reference
//   err            rundown timeout, sticky until next accepted start
module adc_multislope_seq #(
  parameter int unsigned PERIOD_CLKS = 10000,
  parameter int unsigned FIX_CLKS    = 2000,
  parameter int unsigned RESET_CLKS  = 1000,
  parameter int unsigned RUNDOWN_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] nosc,
  input  logic        cmpr_in,
  output logic [2:0]  mux,
  output logic        int_rst,
  output logic        cmpr_latch,
  output logic        busy,
  output logic        done,
  output logic [23:0] count_p,
  output logic [23:0] count_n,
  output logic [23:0] count_rundown,
  output logic        rundown_dir,
  output logic        err
);

  localparam int unsigned CNT_MAX = (PERIOD_CLKS > RESET_CLKS) ? PERIOD_CLKS : RESET_CLKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RD_FLUSH = 3;

  localparam logic [2:0] MUX_OFF  = 3'b000;
  localparam logic [2:0] MUX_RU_P = 3'b101;
  localparam logic [2:0] MUX_RU_N = 3'b110;
  localparam logic [2:0] MUX_RD_P = 3'b001;
  localparam logic [2:0] MUX_RD_N = 3'b010;
  localparam logic [23:0] CNT_SAT = 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INTRESET,
    S_RUNUP,
    S_RUNDOWN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_per;
  logic [15:0]       r_nosc;
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;

  logic w_cmp_s;
  logic w_edge;
  logic w_rst_last;
  logic w_per_last;
  logic w_runup_end;
  logic w_new_period;
  logic w_rd_edge;

  // Synchronised comparator level and its edge (flop 2 vs flop 3)
  assign w_cmp_s = r_s2;
  assign w_edge  = r_s2 ^ r_s3;

  // Outputs are registered, so period-start and fix-phase switching is
  // decided one clock early to make mux change exactly at c=0 / c=P-F.
  assign w_rst_last   = (r_state == S_INTRESET) && (r_cnt == CNT_W'(RESET_CLKS - 1));
  assign w_per_last   = (r_state == S_RUNUP) && (r_cnt == CNT_W'(PERIOD_CLKS - 1));
  assign w_runup_end  = w_per_last && (r_per == (r_nosc - 16'd1));
  assign w_new_period = w_rst_last || (w_per_last && !w_runup_end);

  // Edges inside the first clocks of rundown are stale run-up transitions
  assign w_rd_edge = w_edge && (count_rundown >= 24'(RD_FLUSH));

`ifndef ADC_RUNDOWN_TIMEOUT_EN
  logic w_unused_rdmax;
  assign w_unused_rdmax = ^RUNDOWN_MAX;
`endif

  // Sequencer state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_per         <= '0;
      r_nosc        <= '0;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      mux           <= MUX_OFF;
      int_rst       <= 1'b0;
      cmpr_latch    <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      count_p       <= '0;
      count_n       <= '0;
      count_rundown <= '0;
      rundown_dir   <= 1'b0;
      err           <= 1'b0;
    end else begin
      r_s1 <= cmpr_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start && (nosc != 16'd0)) begin
            r_nosc        <= nosc;
            count_p       <= '0;
            count_n       <= '0;
            count_rundown <= '0;
            rundown_dir   <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b1;
            int_rst       <= 1'b1;
            cmpr_latch    <= 1'b1;
            mux           <= MUX_OFF;
            r_cnt         <= '0;
            r_state       <= S_INTRESET;
          end
        end

        S_INTRESET: begin
          if (w_rst_last) begin
            int_rst    <= 1'b0;
            cmpr_latch <= 1'b0;
            r_cnt      <= '0;
            r_per      <= '0;
            r_state    <= S_RUNUP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RUNUP: begin
          if (w_per_last) begin
            r_cnt <= '0;
            if (w_runup_end) begin
              rundown_dir   <= w_cmp_s;
              mux           <= w_cmp_s ? MUX_RD_N : MUX_RD_P;
              count_rundown <= '0;
              r_state       <= S_RUNDOWN;
            end else begin
              r_per <= r_per + 16'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(PERIOD_CLKS - FIX_CLKS - 1)) begin
              mux <= MUX_RU_P;
            end
          end
        end

        S_RUNDOWN: begin
          if (w_rd_edge) begin
            mux        <= MUX_OFF;
            cmpr_latch <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= S_DONE;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
          end else if (count_rundown == 24'(RUNDOWN_MAX)) begin
            mux        <= MUX_OFF;
            cmpr_latch <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            err        <= 1'b1;
            r_state    <= S_DONE;
`endif
          end else if (count_rundown != CNT_SAT) begin
            count_rundown <= count_rundown + 24'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Variable-phase polarity choice for the period about to start
      if (w_new_period) begin
        if (w_cmp_s) begin
          mux     <= MUX_RU_N;
          count_n <= count_n + 24'd1;
        end else begin
          mux     <= MUX_RU_P;
          count_p <= count_p + 24'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_multislope_seq.sv
// Directed self-checking bench for adc_multislope_seq with
// PERIOD_CLKS=20, FIX_CLKS=5, RESET_CLKS=8, RUNDOWN_MAX=50.
module tb_adc_multislope_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] nosc;
  logic        cmpr_in;
  logic [2:0]  mux;
  logic        int_rst;
  logic        cmpr_latch;
  logic        busy;
  logic        done;
  logic [23:0] count_p;
  logic [23:0] count_n;
  logic [23:0] count_rundown;
  logic        rundown_dir;
  logic        err;

  int checks;
  int errors;

  adc_multislope_seq #(
    .PERIOD_CLKS(20),
    .FIX_CLKS   (5),
    .RESET_CLKS (8),
    .RUNDOWN_MAX(50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .nosc         (nosc),
    .cmpr_in      (cmpr_in),
    .mux          (mux),
    .int_rst      (int_rst),
    .cmpr_latch   (cmpr_latch),
    .busy         (busy),
    .done         (done),
    .count_p      (count_p),
    .count_n      (count_n),
    .count_rundown(count_rundown),
    .rundown_dir  (rundown_dir),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; nosc = 16'd0; cmpr_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mux !== 3'b000) begin errors++; $display("FAIL reset_mux: got %b expected 000", mux); end
    checks++; if (cmpr_latch !== 1'b1) begin errors++; $display("FAIL reset_cmpr_latch: got %b expected 1", cmpr_latch); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (int_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_intrst_err: got %b%b expected 00", int_rst, err); end
    checks++; if (count_p !== 24'd0 || count_n !== 24'd0 || count_rundown !== 24'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", count_p, count_n, count_rundown);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_high_edge();
    int n_rst;
    int n_done;
    int pat_bad;
    bit found;
    logic [2:0] seq[$];
    logic [2:0] exp_mux;
    cmpr_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; nosc = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    n_rst = 0; found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mux == 3'b010) begin found = 1'b1; break; end
      if (int_rst) n_rst++;
      if (mux != 3'b000) seq.push_back(mux);
    end
    checks++; if (!found) begin errors++; $display("FAIL hi_rundown_entry: got no mux=010 expected within 300 clocks"); end
    checks++; if (n_rst != 8) begin errors++; $display("FAIL hi_int_rst_len: got %0d expected 8", n_rst); end
    checks++; if (seq.size() != 80) begin errors++; $display("FAIL hi_runup_len: got %0d expected 80", seq.size()); end
    pat_bad = 0;
    foreach (seq[k]) begin
      exp_mux = ((k % 20) < 15) ? 3'b110 : 3'b101;
      if (seq[k] !== exp_mux) pat_bad++;
    end
    checks++; if (pat_bad != 0) begin errors++; $display("FAIL hi_mux_pattern: got %0d bad clocks expected 0", pat_bad); end
    repeat (37) @(posedge clk);
    #1 cmpr_in = 1'b0;
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        checks++; if (count_rundown !== 24'd39) begin errors++; $display("FAIL hi_count_rundown: got %0d expected 39", count_rundown); end
        checks++; if (count_n !== 24'd4 || count_p !== 24'd0) begin errors++; $display("FAIL hi_counts: got n=%0d p=%0d expected n=4 p=0", count_n, count_p); end
        checks++; if (rundown_dir !== 1'b1) begin errors++; $display("FAIL hi_rundown_dir: got %b expected 1", rundown_dir); end
        checks++; if (mux !== 3'b000 || cmpr_latch !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL hi_done_outputs: got mux=%b latch=%b busy=%b expected 000/1/0", mux, cmpr_latch, busy);
        end
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL hi_done_pulses: got %0d expected 1", n_done); end
  endtask

  task automatic test_alternating();
    bit seen;
    cmpr_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; nosc = 16'd6;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int idx = 0; idx < 400; idx++) begin
      if (done) begin seen = 1'b1; break; end
      if (idx >= 17 && ((idx - 17) % 20) == 0) cmpr_in = ~cmpr_in;
      @(posedge clk);
      #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL alt_done: got no done expected within 400 clocks"); end
    checks++; if (count_p !== 24'd3 || count_n !== 24'd3) begin errors++; $display("FAIL alt_counts: got p=%0d n=%0d expected p=3 n=3", count_p, count_n); end
    checks++; if ((count_p + count_n) !== 24'd6) begin errors++; $display("FAIL alt_sum: got %0d expected 6", count_p + count_n); end
    checks++; if (rundown_dir !== 1'b0) begin errors++; $display("FAIL alt_rundown_dir: got %b expected 0", rundown_dir); end
    checks++; if (count_rundown !== 24'd11) begin errors++; $display("FAIL alt_count_rundown: got %0d expected 11", count_rundown); end
  endtask

  task automatic test_ignored_starts();
    int bad;
    int n_done;
    cmpr_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bad = 0;
    start = 1'b1; nosc = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || int_rst !== 1'b0 || mux !== 3'b000) bad++;
    end
    start = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_nosc0: got %0d clocks with activity expected 0", bad); end
    start = 1'b1; nosc = 16'd1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int idx = 0; idx < 80; idx++) begin
      if (done) begin
        n_done++;
        checks++; if (count_rundown !== 24'd14) begin errors++; $display("FAIL ign_count_rundown: got %0d expected 14", count_rundown); end
      end
      start = (idx < 38) && ((idx % 2) == 1);
      nosc  = 16'd5;
      if (idx == 40) cmpr_in = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL ign_done_pulses: got %0d expected 1", n_done); end
    checks++; if (count_p !== 24'd1 || count_n !== 24'd0) begin errors++; $display("FAIL ign_counts: got p=%0d n=%0d expected p=1 n=0", count_p, count_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midrun();
    bit seen;
    cmpr_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; nosc = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (55) @(posedge clk);
    #1;
    checks++; if (count_p !== 24'd3 || mux !== 3'b101) begin errors++; $display("FAIL mid_pre_reset: got p=%0d mux=%b expected p=3 mux=101", count_p, mux); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mux !== 3'b000) begin errors++; $display("FAIL mid_async_mux: got %b expected 000", mux); end
    checks++; if (busy !== 1'b0 || cmpr_latch !== 1'b1 || int_rst !== 1'b0) begin
      errors++; $display("FAIL mid_async_ctl: got busy=%b latch=%b int_rst=%b expected 0/1/0", busy, cmpr_latch, int_rst);
    end
    checks++; if (count_p !== 24'd0 || count_n !== 24'd0) begin errors++; $display("FAIL mid_counts: got p=%0d n=%0d expected 0/0", count_p, count_n); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmpr_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; nosc = 16'd2;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int idx = 0; idx < 200; idx++) begin
      if (done) begin seen = 1'b1; break; end
      if (idx == 60) cmpr_in = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_restart_done: got no done expected within 200 clocks"); end
    checks++; if (count_n !== 24'd2 || count_p !== 24'd0 || rundown_dir !== 1'b1) begin
      errors++; $display("FAIL mid_restart_counts: got n=%0d p=%0d dir=%b expected 2/0/1", count_n, count_p, rundown_dir);
    end
    checks++; if (count_rundown !== 24'd14) begin errors++; $display("FAIL mid_restart_rundown: got %0d expected 14", count_rundown); end
  endtask

  task automatic test_timeout();
    int n_done;
    cmpr_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; nosc = 16'd1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
    for (int idx = 0; idx < 200; idx++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", err); end
        checks++; if (mux !== 3'b000 || cmpr_latch !== 1'b1) begin errors++; $display("FAIL to_outputs: got mux=%b latch=%b expected 000/1", mux, cmpr_latch); end
        checks++; if (count_rundown !== 24'd50) begin errors++; $display("FAIL to_count_rundown: got %0d expected 50", count_rundown); end
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL to_done_pulses: got %0d expected 1", n_done); end
`else
    for (int idx = 0; idx < 1000; idx++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL noto_busy: got %b expected 1", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL noto_err: got %b expected 0", err); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL noto_done: got %0d pulses expected 0", n_done); end
    checks++; if (mux !== 3'b001) begin errors++; $display("FAIL noto_mux: got %b expected 001", mux); end
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_high_edge();
    test_alternating();
    test_ignored_starts();
    test_reset_midrun();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_multislope_seq.md
Name: adc_multislope_seq

Overview:
- Sequencer for the multi-slope integrating ADC front end.
- On a start request it runs a fixed sequence and then reports the raw counts:
  - shorts/settles the integrator;
  - runs a programmable number of run-up oscillation periods, choosing the reference polarity from the comparator each period;
  - performs a single-slope rundown to the zero crossing.
- Drives the input mux controls (INT_IN_P_CTL / INT_IN_N_CTL / INT_IN_SIG_CTL) and CMPR_LATCH_CTL in the top level.
- Replaces the free-running inline state machine there.

Parameters:
PERIOD_CLKS, 10000, clocks per run-up oscillation period (>= FIX_CLKS+4)
FIX_CLKS, 2000, clocks at end of each period with fixed P reference (charge-injection balance)
RESET_CLKS, 1000, clocks integrator held in reset before run-up
RUNDOWN_MAX, 65535, rundown timeout in clocks (used only with optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  conversion request, sampled in IDLE only
nosc  in  16  run-up periods per conversion, latched on accepted start
cmpr_in  in  1  comparator output (asynchronous to clk)
mux  out  3  {sig, n_ref, p_ref} switch controls, 1 = on
int_rst  out  1  integrator short switch, 1 = shorted
cmpr_latch  out  1  comparator latch, 0 = transparent, 1 = held
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, results valid
count_p  out  24  periods whose variable phase used P reference
count_n  out  24  periods whose variable phase used N reference
count_rundown  out  24  rundown duration in clocks
rundown_dir  out  1  1 = rundown used N reference
err  out  1  rundown timed out (sticky until next accepted start)

Behaviour:
- Reset (async, rst_n=0): state IDLE; mux=000, int_rst=0, cmpr_latch=1, busy=0, done=0, err=0, all counts 0, rundown_dir=0, internal counters 0.
- Comparator input:
  - cmpr_in passes through a 2-flop synchroniser, plus a third flop for edge detection;
  - cmp_s is the synchronised level; an edge is any change between flops 2 and 3.
- IDLE:
  - start=1 and nosc!=0: latch nosc, clear counts and err, busy=1, go to INTRESET.
  - start with nosc==0 is ignored.
- INTRESET:
  - int_rst=1, mux=000, cmpr_latch=1, for RESET_CLKS clocks.
  - Then int_rst=0, cmpr_latch=0, go to RUNUP with period counter 0.
- RUNUP, per period, clock index c = 0..PERIOD_CLKS-1:
  - At c=0: if cmp_s=1, mux=110 and count_n+1; else mux=101 and count_p+1.
  - At c=PERIOD_CLKS-FIX_CLKS: mux=101.
  - After the final clock of the nosc-th period, go to RUNDOWN.
  - count_p+count_n == latched nosc at done.
- RUNDOWN:
  - Entry: rundown_dir=cmp_s; mux=010 if cmp_s=1, else mux=001. Signal is off.
  - count_rundown increments every RUNDOWN clock, saturating at 0xFFFFFF.
  - Edges detected in the first 3 RUNDOWN clocks are ignored (pipeline flush).
  - On a later edge: mux=000, cmpr_latch=1, go to DONE.
- DONE: done=1 for one clock, busy=0, go to IDLE. Counts hold until the next accepted start.
- start while busy is ignored; there is no abort except rst_n.
- Any rst_n assertion mid-conversion immediately forces mux=000 and all reset values.

Optional Feature:
- ADC_RUNDOWN_TIMEOUT_EN defined:
  - If count_rundown reaches RUNDOWN_MAX without an edge: mux=000, cmpr_latch=1, err=1, DONE (done pulses).
- Not defined: RUNDOWN waits indefinitely; err tied 0; RUNDOWN_MAX unused.

Test Plan:
- Bench parameters for all scenarios: PERIOD_CLKS=20, FIX_CLKS=5, RESET_CLKS=8.
- Reset:
  - Stimulus: hold rst_n=0 for 3 clocks.
  - Required: mux=000, cmpr_latch=1, busy=0, done=0, all counts 0.
- Comparator held high, edge in rundown:
  - Stimulus: start, nosc=4, cmpr_in=1; then drop cmpr_in to 0 at RUNDOWN clock 37.
  - Required:
    - int_rst high for exactly 8 clocks;
    - mux=110 for 15 clocks then 101 for 5 clocks, each period;
    - count_n=4, count_p=0, rundown_dir=1;
    - count_rundown=39 (37 + 2-clock sync latency);
    - done pulses once.
- Alternating comparator:
  - Stimulus: cmpr_in toggled before each period start; nosc=6.
  - Required: count_p=3, count_n=3, count_p+count_n=6.
- Ignored starts:
  - Stimulus: start with nosc=0; then start pulses while busy.
  - Required: no state change; exactly one done pulse per accepted start.
- Reset mid-run-up:
  - Stimulus: rst_n=0 in period 2 of RUNUP.
  - Required: mux=000 asynchronously, busy=0, counts 0.
  - A subsequent start completes normally.
- Timeout (macro defined):
  - Stimulus: RUNDOWN_MAX=50, cmpr_in held constant.
  - Required: err=1, mux=000, count_rundown=50, done pulses.
- Same stimulus, macro not defined: still busy after 1000 clocks, err=0.
